// File: rtl/gray_frame_writer.sv
// Grayscale stream sink: packs four 12-bit pixels into three 16-bit words and
// buffers them for the SDRAM write FIFO while tracking raster position.
module gray_frame_writer #(
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                     iCLK,
    input  logic                     iRST,
    input  logic                     iFRAME_START,
    input  logic [11:0]              iPIX12,
    input  logic                     iDVAL,
    output logic [15:0]              oWR_DATA,
    output logic                     oWR_REQ,
    input  logic                     iWR_FULL,
    output logic [$clog2(IMG_W)-1:0] oX,
    output logic [$clog2(IMG_H)-1:0] oY,
    output logic                     oFRAME_DONE,
    output logic                     oOVERFLOW,
    output logic                     oBUSY
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN} state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   x_q, x_d, x_base;
    logic [YW-1:0]   y_q, y_d, y_base;
    logic [1:0]      phase_q, phase_d, phase_base;
    logic [11:0]     resid_q, resid_d;
    logic            ovf_q, ovf_d;
    logic            done_q, done_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [15:0]     mem_q [FIFO_DEPTH];

    logic        fifo_empty, fifo_full, pop, accept, last_pix;
    logic        push, push_ok, drop, drain_done;
    logic [15:0] push_word;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign oWR_REQ    = !fifo_empty && !iWR_FULL;
    assign oWR_DATA   = fifo_empty ? 16'h0000 : mem_q[rd_ptr_q];
    assign pop        = oWR_REQ;

    // A frame start rebases position and pack phase so a same-cycle pixel lands at (0,0) as p0.
    always_comb begin
        // NOTE: every signal gets a default first so no path through this block infers a latch.
        x_base     = iFRAME_START ? '0 : x_q;
        y_base     = iFRAME_START ? '0 : y_q;
        phase_base = iFRAME_START ? 2'd0 : phase_q;
        accept     = iDVAL && ((state_q == S_ACTIVE) || iFRAME_START);
        last_pix   = (x_base == XW'(IMG_W - 1)) && (y_base == YW'(IMG_H - 1));
        push       = accept && (phase_base != 2'd0);

        unique case (phase_base)
            2'd1:    push_word = {iPIX12[3:0], resid_q};
            2'd2:    push_word = {iPIX12[7:0], resid_q[11:4]};
            2'd3:    push_word = {iPIX12, resid_q[11:8]};
            default: push_word = 16'h0000;
        endcase

        push_ok = push && (!fifo_full || pop);
        drop    = push && fifo_full && !pop;

        x_d = x_base;
        y_d = y_base;
        if (accept) begin
            if (x_base == XW'(IMG_W - 1)) begin
                x_d = '0;
                y_d = (y_base == YW'(IMG_H - 1)) ? '0 : y_base + YW'(1);
            end else begin
                x_d = x_base + XW'(1);
            end
        end

        phase_d = accept ? phase_base + 2'd1 : phase_base;
        resid_d = accept ? iPIX12 : resid_q;
        ovf_d   = (iFRAME_START ? 1'b0 : ovf_q) | drop;

        wr_ptr_d = wr_ptr_q + (push_ok ? AW'(1) : AW'(0));
        rd_ptr_d = rd_ptr_q + (pop ? AW'(1) : AW'(0));
        count_d  = count_q;
        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (iFRAME_START) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (iFRAME_START) begin
            state_d = S_ACTIVE;
        end else begin
            unique case (state_q)
                S_ACTIVE: if (accept && last_pix) state_d = S_DRAIN;
                S_DRAIN:  if (fifo_empty) state_d = S_IDLE;
                default:  state_d = state_q;
            endcase
        end
    end

    always_comb begin
        oBUSY      = (state_q != S_IDLE);
        drain_done = (state_q == S_DRAIN) && fifo_empty;
        done_d     = drain_done && !iFRAME_START;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            x_q      <= '0;
            y_q      <= '0;
            phase_q  <= 2'd0;
            resid_q  <= 12'h000;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading the pre-edge values.
            x_q      <= x_d;
            y_q      <= y_d;
            phase_q  <= phase_d;
            resid_q  <= resid_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the word storage is not reset; an empty count masks stale entries.
    always_ff @(posedge iCLK) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_word;
        end
    end

    assign oX          = x_q;
    assign oY          = y_q;
    assign oFRAME_DONE = done_q;
    assign oOVERFLOW   = ovf_q;
endmodule

// File: tb/tb_gray_frame_writer.sv
// Randomized scoreboard bench for gray_frame_writer against a queue-based frame model.
module tb_gray_frame_writer;
    localparam int W = 8;
    localparam int H = 2;
    localparam int D = 8;

    logic        clk = 1'b0;
    logic        rst, fs_i, dval_i, full_i;
    logic [11:0] pix_i;
    logic [15:0] wr_data;
    logic        wr_req, frame_done, ovf, busy;
    logic [2:0]  ox;
    logic [0:0]  oy;

    always #5 clk = ~clk;

    gray_frame_writer #(.IMG_W(W), .IMG_H(H), .FIFO_DEPTH(D)) dut (
        .iCLK(clk), .iRST(rst), .iFRAME_START(fs_i), .iPIX12(pix_i), .iDVAL(dval_i),
        .oWR_DATA(wr_data), .oWR_REQ(wr_req), .iWR_FULL(full_i),
        .oX(ox), .oY(oy), .oFRAME_DONE(frame_done), .oOVERFLOW(ovf), .oBUSY(busy)
    );

    typedef struct {bit req; logic [15:0] data;} exp_t;
    typedef enum {M_IDLE, M_ACTIVE, M_DRAIN} mst_t;

    exp_t        exp_q[$];
    logic [15:0] m_fifo[$];
    logic [11:0] m_grp[$];
    int          m_x, m_y;
    bit          m_ovf, m_done;
    mst_t        m_st;
    int          checks = 0, errors = 0, words_seen = 0, done_seen = 0;
    bit          mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_fifo.delete();
        m_grp.delete();
        m_x = 0; m_y = 0; m_ovf = 1'b0; m_done = 1'b0; m_st = M_IDLE;
    endfunction

    // One clock of stimulus; the model advances to the state expected after the edge.
    task automatic step(input bit fs, input bit dv, input logic [11:0] px, input bit full, input bit r);
        int sz;
        bit pop, done_next, has_w;
        exp_t e;
        logic [11:0] a, b, c, d;
        logic [15:0] w;
        rst = r; fs_i = fs; dval_i = dv; pix_i = px; full_i = full;
        sz = m_fifo.size();
        e.req  = (sz > 0) && !full;
        e.data = (sz > 0) ? m_fifo[0] : 16'h0000;
        exp_q.push_back(e);
        if (r) begin
            model_reset();
        end else begin
            pop = e.req;
            if (pop) void'(m_fifo.pop_front());
            done_next = (m_st == M_DRAIN) && (sz == 0) && !fs;
            if (fs) begin
                m_fifo.delete(); m_grp.delete();
                m_x = 0; m_y = 0; m_ovf = 1'b0; m_st = M_ACTIVE;
            end else if (m_st == M_DRAIN && sz == 0) begin
                m_st = M_IDLE;
            end
            if (dv && m_st == M_ACTIVE) begin
                m_grp.push_back(px);
                has_w = 1'b1;
                w = 16'h0000;
                if (m_grp.size() == 2) begin
                    a = m_grp[0]; b = m_grp[1]; w = {b[3:0], a};
                end else if (m_grp.size() == 3) begin
                    b = m_grp[1]; c = m_grp[2]; w = {c[7:0], b[11:4]};
                end else if (m_grp.size() == 4) begin
                    c = m_grp[2]; d = m_grp[3]; w = {d, c[11:8]};
                    m_grp.delete();
                end else begin
                    has_w = 1'b0;
                end
                if (has_w) begin
                    if (sz == D && !pop) m_ovf = 1'b1;
                    else m_fifo.push_back(w);
                end
                if (m_x == W - 1) begin
                    m_x = 0;
                    if (m_y == H - 1) begin m_y = 0; m_st = M_DRAIN; end
                    else m_y++;
                end else begin
                    m_x++;
                end
            end
            m_done = done_next;
        end
        @(posedge clk); #1;
        check("x", 32'(ox), m_x);
        check("y", 32'(oy), m_y);
        check("busy", 32'(busy), 32'(m_st != M_IDLE));
        check("overflow", 32'(ovf), 32'(m_ovf));
        check("frame_done", 32'(frame_done), 32'(m_done));
        if (frame_done) done_seen++;
    endtask

    task automatic send(input int n, input bit full, input int gap_pct);
        for (int i = 0; i < n; i++) begin
            while (int'($urandom_range(99)) < gap_pct) step(0, 0, 12'($urandom), full, 0);
            step(0, 1, 12'($urandom), full, 0);
        end
    endtask

    task automatic drain();
        int budget = 200;
        while (m_st != M_IDLE && budget > 0) begin
            step(0, 0, 12'h000, 0, 0);
            budget--;
        end
        if (budget == 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout actual=busy required=idle");
        end
    endtask

    // Scoreboard monitor: compares the write port mid-cycle against queued expectations.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL scoreboard_empty actual=none required=entry at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_req", 32'(wr_req), 32'(e.req));
                    check("wr_data", 32'(wr_data), 32'(e.data));
                    if (wr_req) words_seen++;
                end
            end
        end
    end

    initial begin
        int base_w, base_d;
        rst = 1'b1; fs_i = 1'b0; dval_i = 1'b0; pix_i = 12'h000; full_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_x", 32'(ox), 0);
        check("rst_y", 32'(oy), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_req", 32'(wr_req), 0);
        check("rst_data", 32'(wr_data), 0);
        check("rst_ovf", 32'(ovf), 0);
        model_reset();
        mon_en = 1'b1;

        // Idle pixels are ignored.
        for (int i = 0; i < 10; i++) step(0, 1'($urandom), 12'($urandom), 0, 0);
        check("idle_words", words_seen, 0);

        // Packing values and a full frame with gaps.
        base_w = words_seen; base_d = done_seen;
        step(1, 0, 12'h000, 0, 0);
        step(0, 1, 12'h123, 0, 0);
        step(0, 1, 12'h456, 0, 0);
        check("pack_w0", 32'(wr_data), 32'h6123);
        step(0, 1, 12'h789, 0, 0);
        check("pack_w1", 32'(wr_data), 32'h8945);
        step(0, 1, 12'hABC, 0, 0);
        check("pack_w2", 32'(wr_data), 32'hABC7);
        send(12, 0, 30);
        drain();
        step(0, 0, 12'h000, 0, 0);
        check("frame_words", words_seen - base_w, 12);
        check("frame_done_cnt", done_seen - base_d, 1);

        // Backpressure: fill, push+pop while full, then overflow, then release.
        base_w = words_seen;
        step(1, 0, 12'h000, 1, 0);
        send(11, 1, 20);
        send(1, 0, 0);
        check("full_pushpop_ovf", 32'(ovf), 0);
        send(4, 1, 0);
        check("bp_ovf", 32'(ovf), 1);
        drain();
        check("bp_words", words_seen - base_w, 9);

        // Restart mid-frame with a same-cycle pixel.
        step(1, 0, 12'h000, 1, 0);
        send(14, 1, 0);
        step(1, 1, 12'($urandom), 1, 0);
        check("restart_x", 32'(ox), 1);
        check("restart_ovf", 32'(ovf), 0);
        send(15, 0, 20);
        drain();

        // Reset mid-frame, including reset overriding a frame start.
        step(1, 0, 12'h000, 1, 0);
        send(6, 1, 0);
        step(0, 1, 12'($urandom), 1, 1);
        step(1, 1, 12'($urandom), 0, 1);
        check("rst_mid_busy", 32'(busy), 0);
        step(0, 0, 12'h000, 0, 0);
        check("rst_mid_req", 32'(wr_req), 0);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(39) == 0), ($urandom_range(3) != 0), 12'($urandom),
                 ($urandom_range(9) < 3), ($urandom_range(399) == 0));
        end
        drain();
        repeat (3) step(0, 0, 12'h000, 0, 0);
        mon_en = 1'b0;
        check("scoreboard_left", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
